bram_port_arbiter: RTL and testbench

- Shares one native BRAM port between two requesters, e.g. two AXI-Lite BRAM bridges, or a bridge plus a DMA engine.
- Round-robin arbitration with at most one command per cycle, issued to the BRAM as a registered command.
- Tracks BRAM read latency and returns read data to the requester that issued the read, through a per-port response register with valid/ready.

---
 rtl/bram_arb_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/bram_port_arbiter.sv | 132 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the two-port BRAM arbiter.
// Optional statistics are enabled with BRAM_ARB_STATS_EN (see bram_port_arbiter).
package bram_arb_pkg;

    localparam int unsigned NUM_PORTS    = 2;
    localparam int unsigned MAX_WE_BYTES = 128;

    typedef logic [0:0] port_idx_t;

    typedef struct packed {
        logic      valid;
        port_idx_t port;
    } tag_t;

    // All-zero byte enables denote a read; callers zero-extend to MAX_WE_BYTES.
    function automatic logic is_read(input logic [MAX_WE_BYTES-1:0] we);
        return (we == '0);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; pointer advances only when a grant is accepted.
module rr_arbiter2
    import bram_arb_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_PORTS-1:0] i_eligible,
    input  logic                 i_accept,
    output logic [NUM_PORTS-1:0] o_grant
);

    port_idx_t r_last_grant;

    always_comb begin
        o_grant = '0;
        case (i_eligible)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_last_grant == 1'b1) ? 2'b01 : 2'b10;
            default: o_grant = '0;
        endcase
    end

    // Reset to port 1 so that port 0 wins the first conflict.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (i_accept) begin
            r_last_grant <= o_grant[1];
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one native BRAM port between two requesters with round-robin issue and per-port read return.
// Define BRAM_ARB_STATS_EN to add grant/conflict counters with stat_clear.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic [NUM_PORTS-1:0]                   s_req_valid,
    output logic [NUM_PORTS-1:0]                   s_req_ready,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   s_req_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] s_req_we,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   s_req_wrdata,
    output logic [NUM_PORTS-1:0]                   s_rsp_valid,
    input  logic [NUM_PORTS-1:0]                   s_rsp_ready,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   s_rsp_rdata,
    output logic                                   bram_en,
    output logic [DATA_WIDTH/8-1:0]                bram_we,
    output logic [ADDR_WIDTH-1:0]                  bram_addr,
    output logic [DATA_WIDTH-1:0]                  bram_wrdata,
    input  logic [DATA_WIDTH-1:0]                  bram_rddata
`ifdef BRAM_ARB_STATS_EN
    ,
    input  logic                                   stat_clear,
    output logic [NUM_PORTS-1:0][31:0]             stat_grant_cnt,
    output logic [31:0]                            stat_conflict_cnt
`endif
);

    logic [NUM_PORTS-1:0]                 w_rsp_hs;
    logic [NUM_PORTS-1:0]                 w_is_rd;
    logic [NUM_PORTS-1:0]                 w_eligible;
    logic [NUM_PORTS-1:0]                 w_grant;
    logic                                 w_accept;
    port_idx_t                            w_sel;

    logic [NUM_PORTS-1:0]                 r_outstanding;
    logic [NUM_PORTS-1:0]                 r_rsp_valid;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_rsp_rdata;
    tag_t                                 r_tag [RD_LATENCY+1];

    // A response handshake frees the port for a new read in the same cycle.
    always_comb begin
        w_rsp_hs   = '0;
        w_is_rd    = '0;
        w_eligible = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_rsp_hs[i]   = r_rsp_valid[i] & s_rsp_ready[i];
            w_is_rd[i]    = is_read(MAX_WE_BYTES'(s_req_we[i]));
            w_eligible[i] = s_req_valid[i] & (~w_is_rd[i] | ~r_outstanding[i] | w_rsp_hs[i]);
        end
    end

    rr_arbiter2 u_rr (
        .i_clk      (aclk),
        .i_rst      (areset),
        .i_eligible (w_eligible),
        .i_accept   (w_accept),
        .o_grant    (w_grant)
    );

    assign w_accept    = |w_grant;
    assign w_sel       = w_grant[1];
    assign s_req_ready = w_grant;
    assign s_rsp_valid = r_rsp_valid;
    assign s_rsp_rdata = r_rsp_rdata;

    always_ff @(posedge aclk) begin
        if (areset) begin
            bram_en       <= 1'b0;
            bram_we       <= '0;
            bram_addr     <= '0;
            bram_wrdata   <= '0;
            r_outstanding <= '0;
            r_rsp_valid   <= '0;
            r_rsp_rdata   <= '0;
            for (int unsigned k = 0; k <= RD_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            bram_en <= w_accept;
            bram_we <= w_accept ? s_req_we[w_sel] : '0;
            if (w_accept) begin
                bram_addr   <= s_req_addr[w_sel];
                bram_wrdata <= s_req_wrdata[w_sel];
            end

            // Stage RD_LATENCY lines up with bram_rddata for the read it tags.
            r_tag[0] <= '{valid: w_accept & w_is_rd[w_sel], port: w_sel};
            for (int unsigned k = 1; k <= RD_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end

            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (w_grant[i] && w_is_rd[i]) begin
                    r_outstanding[i] <= 1'b1;
                end else if (w_rsp_hs[i]) begin
                    r_outstanding[i] <= 1'b0;
                end

                if (r_tag[RD_LATENCY].valid && (r_tag[RD_LATENCY].port == port_idx_t'(i))) begin
                    r_rsp_valid[i] <= 1'b1;
                    r_rsp_rdata[i] <= bram_rddata;
                end else if (w_rsp_hs[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

`ifdef BRAM_ARB_STATS_EN
    always_ff @(posedge aclk) begin
        if (areset || stat_clear) begin
            stat_grant_cnt    <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (w_grant[i]) begin
                    stat_grant_cnt[i] <= stat_grant_cnt[i] + 32'd1;
                end
            end
            if (&w_eligible) begin
                stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_bram_port_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int WEW = DW / 8;
    localparam int RDL = 1;

    logic                    aclk = 1'b0;
    logic                    areset;
    logic [1:0]              s_req_valid;
    logic [1:0]              s_req_ready;
    logic [1:0][AW-1:0]      s_req_addr;
    logic [1:0][WEW-1:0]     s_req_we;
    logic [1:0][DW-1:0]      s_req_wrdata;
    logic [1:0]              s_rsp_valid;
    logic [1:0]              s_rsp_ready;
    logic [1:0][DW-1:0]      s_rsp_rdata;
    logic                    bram_en;
    logic [WEW-1:0]          bram_we;
    logic [AW-1:0]           bram_addr;
    logic [DW-1:0]           bram_wrdata;
    logic [DW-1:0]           bram_rddata;
`ifdef BRAM_ARB_STATS_EN
    logic                    stat_clear;
    logic [1:0][31:0]        stat_grant_cnt;
    logic [31:0]             stat_conflict_cnt;
`endif

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req_addr   (s_req_addr),
        .s_req_we     (s_req_we),
        .s_req_wrdata (s_req_wrdata),
        .s_rsp_valid  (s_rsp_valid),
        .s_rsp_ready  (s_rsp_ready),
        .s_rsp_rdata  (s_rsp_rdata),
        .bram_en      (bram_en),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_wrdata  (bram_wrdata),
        .bram_rddata  (bram_rddata)
`ifdef BRAM_ARB_STATS_EN
        ,
        .stat_clear        (stat_clear),
        .stat_grant_cnt    (stat_grant_cnt),
        .stat_conflict_cnt (stat_conflict_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // External BRAM: byte-write memory with RD_LATENCY read pipeline; garbage when idle.
    bit   [DW-1:0] bram_mem [1<<AW];
    logic [DW-1:0] rd_pipe  [RDL];
    always @(posedge aclk) begin
        if (bram_en) begin
            for (int b = 0; b < WEW; b++)
                if (bram_we[b]) bram_mem[bram_addr][8*b +: 8] <= bram_wrdata[8*b +: 8];
            rd_pipe[0] <= bram_mem[bram_addr];
        end else begin
            rd_pipe[0] <= $urandom;
        end
        for (int k = 1; k < RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bram_rddata = rd_pipe[RDL-1];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a memory image updated in acceptance order, per-port pending reads, RR pointer.
    typedef struct { bit en; logic [WEW-1:0] we; logic [AW-1:0] addr; logic [DW-1:0] wd; } cmd_t;
    typedef struct { logic [DW-1:0] data; int due; } rsp_t;

    bit   [DW-1:0] sh_mem [1<<AW];
    rsp_t          exp_q [2][$];
    cmd_t          cmd_q [$];
    bit   [1:0]    m_out;
    bit            m_last;
    bit            m_live = 1'b0;
    bit            m_rst_chk;
    int unsigned   m_gcnt [2];
    int unsigned   m_ccnt;

    cmd_t       ec;
    bit         exp_v;
    logic [1:0] elig, eg;
    bit         g;

    always @(negedge aclk) begin
        if (m_live) begin
            if (cmd_q.size() == 0) begin
                check("cmd_model_empty", 64'(1), 64'(0));
            end else begin
                ec = cmd_q.pop_front();
                check("bram_en", 64'(bram_en), 64'(ec.en));
                check("bram_we", 64'(bram_we), 64'(ec.we));
                if (ec.en) check("bram_addr", 64'(bram_addr), 64'(ec.addr));
                if (ec.en && ec.we != 0) check("bram_wrdata", 64'(bram_wrdata), 64'(ec.wd));
            end
            if (m_rst_chk) begin
                check("rst_bram_addr", 64'(bram_addr), 64'(0));
                check("rst_bram_wrdata", 64'(bram_wrdata), 64'(0));
                check("rst_rsp_rdata0", 64'(s_rsp_rdata[0]), 64'(0));
                check("rst_rsp_rdata1", 64'(s_rsp_rdata[1]), 64'(0));
                m_rst_chk = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                exp_v = (exp_q[p].size() != 0) && (cyc >= exp_q[p][0].due);
                check($sformatf("rsp_valid%0d", p), 64'(s_rsp_valid[p]), 64'(exp_v));
                if (exp_v) begin
                    check($sformatf("rsp_rdata%0d", p), 64'(s_rsp_rdata[p]), 64'(exp_q[p][0].data));
                    if (s_rsp_ready[p]) begin
                        void'(exp_q[p].pop_front());
                        m_out[p] = 1'b0;
                    end
                end
            end
`ifdef BRAM_ARB_STATS_EN
            check("stat_grant0", 64'(stat_grant_cnt[0]), 64'(m_gcnt[0]));
            check("stat_grant1", 64'(stat_grant_cnt[1]), 64'(m_gcnt[1]));
            check("stat_conflict", 64'(stat_conflict_cnt), 64'(m_ccnt));
`endif
            for (int p = 0; p < 2; p++)
                elig[p] = s_req_valid[p] && ((s_req_we[p] != 0) || !m_out[p]);
            eg = (elig == 2'b11) ? (m_last ? 2'b01 : 2'b10) : elig;
            check("req_ready", 64'(s_req_ready), 64'(eg));
        end

        if (areset) begin
            exp_q[0].delete();
            exp_q[1].delete();
            cmd_q.delete();
            cmd_q.push_back('{1'b0, '0, '0, '0});
            m_out     = '0;
            m_last    = 1'b1;
            m_rst_chk = 1'b1;
            m_live    = 1'b1;
            m_gcnt    = '{0, 0};
            m_ccnt    = 0;
        end else if (m_live) begin
            if (eg != 2'b00) begin
                g = eg[1];
                if (s_req_we[g] != 0) begin
                    for (int b = 0; b < WEW; b++)
                        if (s_req_we[g][b]) sh_mem[s_req_addr[g]][8*b +: 8] = s_req_wrdata[g][8*b +: 8];
                end else begin
                    exp_q[g].push_back('{sh_mem[s_req_addr[g]], cyc + 2 + RDL});
                    m_out[g] = 1'b1;
                end
                cmd_q.push_back('{1'b1, s_req_we[g], s_req_addr[g], s_req_wrdata[g]});
                m_last = g;
            end else begin
                cmd_q.push_back('{1'b0, '0, '0, '0});
            end
`ifdef BRAM_ARB_STATS_EN
            if (stat_clear) begin
                m_gcnt = '{0, 0};
                m_ccnt = 0;
            end else begin
                if (eg != 2'b00) m_gcnt[eg[1]]++;
                if (elig == 2'b11) m_ccnt++;
            end
`endif
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_port(input int p, input bit v, input logic [WEW-1:0] we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_req_valid[p]  = v;
        s_req_we[p]     = we;
        s_req_addr[p]   = a;
        s_req_wrdata[p] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        areset       = 1'b1;
        s_req_valid  = '0;
        s_req_we     = '0;
        s_req_addr   = '0;
        s_req_wrdata = '0;
        s_rsp_ready  = 2'b11;
`ifdef BRAM_ARB_STATS_EN
        stat_clear   = 1'b0;
`endif
        repeat (3) step();
        areset = 1'b0;

        // Write then read back on port 0.
        set_port(0, 1, 4'hF, 16'h0010, 32'hDEADBEEF);
        step();
        set_port(0, 0, 4'h0, 16'h0000, 32'h0);
        step();
        set_port(0, 1, 4'h0, 16'h0010, 32'h0);
        step();
        set_port(0, 0, 4'h0, 16'h0000, 32'h0);
        repeat (6) step();

        // Both ports reading continuously.
        for (int i = 0; i < 24; i++) begin
            set_port(0, 1, 4'h0, 16'($urandom_range(0, 7)), 32'h0);
            set_port(1, 1, 4'h0, 16'($urandom_range(8, 15)), 32'h0);
            step();
        end
        s_req_valid = '0;
        repeat (4) step();

        // Port 0 response stalled while port 1 writes every cycle.
        s_rsp_ready[0] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            set_port(0, 1, 4'h0, 16'h0003, 32'h0);
            set_port(1, 1, 4'($urandom_range(1, 15)), 16'($urandom_range(0, 7)), $urandom);
            step();
        end
        s_rsp_ready[0] = 1'b1;
        repeat (4) step();
        s_req_valid = '0;
        repeat (4) step();

        // Reset one cycle after a read is accepted, then a conflict.
        set_port(0, 1, 4'h0, 16'h0005, 32'h0);
        step();
        s_req_valid = '0;
        areset = 1'b1;
        step();
        areset = 1'b0;
        set_port(0, 1, 4'h0, 16'h0001, 32'h0);
        set_port(1, 1, 4'h0, 16'h0002, 32'h0);
        step();
        s_req_valid = '0;
        repeat (6) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < 2; p++) begin
                set_port(p, ($urandom_range(0, 3) != 0),
                         ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                         16'($urandom_range(0, 15)), $urandom);
                s_rsp_ready[p] = ($urandom_range(0, 9) < 7);
            end
            areset = ($urandom_range(0, 499) == 0);
`ifdef BRAM_ARB_STATS_EN
            stat_clear = ($urandom_range(0, 49) == 0);
`endif
            step();
        end
        areset      = 1'b0;
        s_req_valid = '0;
        s_rsp_ready = 2'b11;
`ifdef BRAM_ARB_STATS_EN
        stat_clear  = 1'b0;
`endif
        for (int i = 0; i < 60 && (exp_q[0].size() + exp_q[1].size()) != 0; i++) step();
        check("drain_pending", 64'(exp_q[0].size() + exp_q[1].size()), 64'(0));
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
